// File: rtl/score_tracker.sv
// score_tracker: BCD pipe-clear score, session high score and display sequencing for a 4-digit 7-seg driver
//   clock_100Mhz  : system clock, rising edge
//   reset_n       : asynchronous active-low reset
//   game_start    : starts a round from IDLE or OVER
//   game_over     : ends the round while PLAYING
//   pass_event    : pipe cleared; rising edges count
//   display_bcd   : registered packed-BCD digits for the display driver
//   display_blank : blanks all anodes (new-high-score blink)
//   score_bcd     : current round score, packed BCD
//   high_bcd      : session high score, packed BCD
//   new_high      : last completed round set a new high score
//   playing       : round in progress
// Define SCORE_TRACKER_HIGH_SCORE_EN to build the high-score register, new_high and blink;
// without it high_bcd, new_high and display_blank are 0 and IDLE shows 0000.
module score_tracker #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic        clock_100Mhz,
  input  logic        reset_n,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        pass_event,
  output logic [15:0] display_bcd,
  output logic        display_blank,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic        new_high,
  output logic        playing
);
  typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;
  state_t state, state_n;
  logic pass_d, start, stop, inc;
  logic [15:0] score_n, high_n;
  if (BLINK_CYCLES < 2) begin : g_bad_blink
    $error("BLINK_CYCLES must be at least 2");
  end
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++)
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    return r;
  endfunction
  always_comb begin
    start   = game_start && state != PLAYING;
    stop    = game_over && state == PLAYING;
    inc     = state == PLAYING && !game_over && pass_event && !pass_d;
    state_n = start ? PLAYING : stop ? OVER : state;
    score_n = start ? 16'h0 : inc ? bcd_inc(score_bcd) : score_bcd;
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
    high_n  = (stop && score_bcd > high_bcd) ? score_bcd : high_bcd;
`else
    high_n  = 16'h0;
`endif
  end
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
  localparam int CW = $clog2(BLINK_CYCLES);
  logic [CW-1:0] blink_cnt;
`else
  assign high_bcd      = 16'h0;
  assign new_high      = 1'b0;
  assign display_blank = 1'b0;
`endif
  // display_bcd is built from next-state values so it lands on the same edge as the change it shows
  always_ff @(posedge clock_100Mhz or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      score_bcd   <= 16'h0;
      display_bcd <= 16'h0;
      playing     <= 1'b0;
      pass_d      <= 1'b0;
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
      high_bcd      <= 16'h0;
      new_high      <= 1'b0;
      display_blank <= 1'b0;
      blink_cnt     <= '0;
`endif
    end else begin
      state       <= state_n;
      score_bcd   <= score_n;
      pass_d      <= pass_event;
      playing     <= state_n == PLAYING;
      display_bcd <= state_n == IDLE ? high_n : score_n;
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
      high_bcd <= high_n;
      new_high <= start ? 1'b0 : (stop && score_bcd > high_bcd) ? 1'b1 : new_high;
      if (start) begin
        blink_cnt     <= '0;
        display_blank <= 1'b0;
      end else if (state == OVER && new_high) begin
        if (blink_cnt == CW'(BLINK_CYCLES - 1)) begin
          blink_cnt     <= '0;
          display_blank <= ~display_blank;
        end else blink_cnt <= blink_cnt + 1'b1;
      end
`endif
    end
endmodule

// File: doc/score_tracker.md
# score_tracker

Game-side scoring stage that sits directly upstream of the four-digit seven-segment display driver. It counts pipe-clear events during play as a 4-digit packed BCD score, keeps a session high score, and sequences what the display shows across idle, play and game-over. It presents ready-made BCD digits, so the downstream driver only multiplexes and decodes and never divides.

## Interface
- `BLINK_CYCLES`, default 25_000_000: half-period, in clock cycles, of the new-high-score blink (250 ms at 100 MHz); must be ≥ 2.
- `clock_100Mhz` input 1: system clock; all logic is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `game_start` input 1: level, synchronous; starts a new round when sampled high in IDLE or OVER.
- `game_over` input 1: level, synchronous; ends the round when sampled high in PLAYING.
- `pass_event` input 1: synchronous; the bird cleared a pipe; may stay high for many cycles; only rising edges count.
- `display_bcd` output 16: digit to show; [15:12] thousands down to [3:0] units; registered.
- `display_blank` output 1: 1 = downstream driver turns off all anodes.
- `score_bcd` output 16: current round score, packed BCD.
- `high_bcd` output 16: session high score, packed BCD.
- `new_high` output 1: the last completed round set a new high score.
- `playing` output 1: high in PLAYING.

## Operation
- Reset: state IDLE; `score_bcd`, `high_bcd`, `display_bcd` = 0; `display_blank`, `new_high`, `playing` = 0; edge register and blink counter = 0.
- States:
  - IDLE: `game_start` → PLAYING.
  - PLAYING: `game_over` → OVER.
  - OVER: `game_start` → PLAYING.
  - No other transitions. `game_over` is ignored outside PLAYING. `game_start` is ignored in PLAYING.
- Entering PLAYING: on the same edge, `score_bcd` ← 0, `new_high` ← 0, blink counter ← 0.
- Edge detect: `pass_d` ← `pass_event` every cycle, in all states. An increment is due when `pass_event & ~pass_d` is true in PLAYING.
- Increment: packed-BCD +1 with decimal carry across all four digits, e.g. 0099 → 0100 and 0999 → 1000. Saturates at 9999: further edges leave it at 9999.
- Priority in PLAYING: if `game_over` is high, the pass edge in that cycle is discarded.
- Entering OVER: if `score_bcd` > `high_bcd`, then `high_bcd` ← `score_bcd` and `new_high` ← 1. The compare is plain 16-bit unsigned, which is valid for packed BCD. An equal score does not set `new_high`.
- `display_bcd` source by state: IDLE → `high_bcd`; PLAYING and OVER → `score_bcd`.
- `display_blank`:
  - 0 in IDLE and PLAYING, and in OVER when `new_high` = 0.
  - In OVER with `new_high` = 1: the blink counter counts 0..BLINK_CYCLES−1 and wraps; `display_blank` toggles at each wrap. The first toggle comes BLINK_CYCLES cycles after entering OVER.

## Timing
- Pass edge sampled at edge N: `score_bcd` and `display_bcd` show the new value after edge N. Latency is 1 cycle from `pass_event` rising.
- A held `pass_event` counts once. To count a second time it must be low for at least one cycle.
- `game_over` sampled at edge N: `playing` = 0, `high_bcd` and `new_high` are updated after edge N; `display_bcd` is unchanged.
- `game_start` sampled at edge N: `score_bcd` = 0 and `display_bcd` = 0 after edge N.
- `display_bcd` follows the state and the sources with exactly 1 cycle of register latency; no glitches.
- Reset asserted mid-round: every output returns to its reset value immediately, with no clock needed. The high score is lost.

## Configuration
- `SCORE_TRACKER_HIGH_SCORE_EN`, defined:
  - High-score register, compare logic, `new_high` and blink are implemented as above.
- Not defined:
  - `high_bcd` and `new_high` are tied to 0, and `display_blank` is tied to 0.
  - The blink counter is removed.
  - IDLE shows 0000.
  - All other behaviour is identical.

## Test plan
- Reset, then `game_start` for 1 cycle, then 3 single-cycle `pass_event` pulses → `score_bcd` = 0x0003, `display_bcd` = 0x0003, each update 1 cycle after its pulse.
- `pass_event` held high for 50 cycles in PLAYING → score increments exactly once.
- Preload 99 passes, then 1 more → 0x0100. Drive 10 000 passes → saturates at 0x9999.
- Round 1: 5 passes, then `game_over` → `high_bcd` = 0x0005, `new_high` = 1, `display_blank` toggles every BLINK_CYCLES (use BLINK_CYCLES = 4). Round 2: 5 passes, then `game_over` → `new_high` = 0, no blink. Return to IDLE by reset is not allowed; check that `game_start` clears the score.
- `game_over` and a pass edge in the same cycle at score 0x0007 → score stays 0x0007, state OVER. `game_start` and `game_over` together in IDLE → PLAYING.
- `reset_n` pulsed low mid-round with score 0x0042 → all outputs 0 asynchronously, state IDLE. Repeat with the macro undefined → `high_bcd` stays 0 throughout.
